// File: rtl/apple1_ram_arbiter.sv
// Shares the Apple-1 RAM between the CPU and the host download stream.
// The CPU always wins. Download bytes queue in a small FIFO and drain into
// RAM in cycles where the CPU makes no in-range access.
module apple1_ram_arbiter #(
    parameter int unsigned RAM_AW     = 13,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          HOLD_CPU   = 1'b1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [7:0]        cpu_rdata,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [15:0]       dl_addr,
    input  logic [7:0]        dl_data,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    input  logic [7:0]        ram_dout,
    output logic              cpu_hold,
    output logic              dl_busy,
    output logic              dl_done,
    output logic              dl_overflow,
    output logic              dl_range_err,
    output logic [15:0]       dl_count
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = RAM_AW + 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nx;

    logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   fifo_count;
    logic [EW-1:0]   head;

    logic            dl_active_q;
    logic            dl_rise;
    logic            cpu_acc;
    logic            dl_in_range;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            push;
    logic            ovf_set;
    logic            rerr_set;

    // Access classification and FIFO handshake
    always_comb begin
        cpu_acc     = (cpu_rd | cpu_wr) && (cpu_addr[15:RAM_AW] == '0);
        dl_in_range = (dl_addr[15:RAM_AW] == '0);
        fifo_empty  = (fifo_count == '0);
        fifo_full   = (fifo_count == CW'(FIFO_DEPTH));
        pop         = ~fifo_empty & ~cpu_acc;
        push        = dl_wr & dl_in_range & (~fifo_full | pop);
        ovf_set     = dl_wr & dl_in_range & fifo_full & ~pop;
        rerr_set    = dl_wr & ~dl_in_range;
        dl_rise     = dl_active & ~dl_active_q;
        head        = fifo_mem[rd_ptr];
    end

    // FIFO payload storage; contents need no reset, occupancy is tracked separately
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {dl_addr[RAM_AW-1:0], dl_data};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    // Load state register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Load sequencing
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (dl_active) state_nx = S_LOAD;
            S_LOAD:  if (!dl_active) state_nx = S_DRAIN;
            S_DRAIN: begin
                if (dl_active) begin
                    state_nx = S_LOAD;
                end else if (fifo_empty) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Registered status; busy/done track the state, hold lags it by one cycle
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_active_q <= 1'b0;
            cpu_hold    <= 1'b0;
            dl_busy     <= 1'b0;
            dl_done     <= 1'b0;
        end else begin
            dl_active_q <= dl_active;
            cpu_hold    <= HOLD_CPU && ((state == S_LOAD) || (state == S_DRAIN));
            dl_busy     <= (state_nx != S_IDLE);
            dl_done     <= (state_nx == S_DONE);
        end
    end

    // Per-load statistics; a new load clears them, events in the same cycle still count
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_overflow  <= 1'b0;
            dl_range_err <= 1'b0;
            dl_count     <= '0;
        end else begin
            dl_overflow  <= (dl_overflow & ~dl_rise) | ovf_set;
            dl_range_err <= (dl_range_err & ~dl_rise) | rerr_set;
            dl_count     <= (dl_rise ? 16'd0 : dl_count) + 16'(pop);
        end
    end

    // RAM port mux: CPU first, then FIFO head, otherwise park on the CPU address
    always_comb begin
        ram_addr = cpu_addr[RAM_AW-1:0];
        ram_din  = cpu_wdata;
        ram_we   = 1'b0;
        if (cpu_acc) begin
            ram_we = cpu_wr;
        end else if (pop) begin
            ram_addr = head[EW-1:8];
            ram_din  = head[7:0];
            ram_we   = 1'b1;
        end
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    assign cpu_rdata = ram_dout;

endmodule

// File: tb/tb_apple1_ram_arbiter.sv
// Randomized and directed bench for apple1_ram_arbiter with a queue-based
// reference model of the download path and an image of the expected RAM.
module tb_apple1_ram_arbiter;

    localparam int unsigned RAM_AW = 13;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned MSIZE  = 8192;

    logic              clk_sys = 1'b0;
    logic              reset   = 1'b1;
    logic [15:0]       cpu_addr = '0;
    logic [7:0]        cpu_wdata = '0;
    logic              cpu_rd = 1'b0;
    logic              cpu_wr = 1'b0;
    logic [7:0]        cpu_rdata;
    logic              dl_active = 1'b0;
    logic              dl_wr = 1'b0;
    logic [15:0]       dl_addr = '0;
    logic [7:0]        dl_data = '0;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_din;
    logic              ram_we;
    logic [7:0]        ram_dout;
    logic              cpu_hold;
    logic              dl_busy;
    logic              dl_done;
    logic              dl_overflow;
    logic              dl_range_err;
    logic [15:0]       dl_count;

    apple1_ram_arbiter #(
        .RAM_AW(RAM_AW),
        .FIFO_DEPTH(DEPTH),
        .HOLD_CPU(1'b1)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rd(cpu_rd),
        .cpu_wr(cpu_wr),
        .cpu_rdata(cpu_rdata),
        .dl_active(dl_active),
        .dl_wr(dl_wr),
        .dl_addr(dl_addr),
        .dl_data(dl_data),
        .ram_addr(ram_addr),
        .ram_din(ram_din),
        .ram_we(ram_we),
        .ram_dout(ram_dout),
        .cpu_hold(cpu_hold),
        .dl_busy(dl_busy),
        .dl_done(dl_done),
        .dl_overflow(dl_overflow),
        .dl_range_err(dl_range_err),
        .dl_count(dl_count)
    );

    always #5 clk_sys = ~clk_sys;

    // Synchronous single-port RAM, read-before-write
    logic [7:0] ram [0:MSIZE-1];
    always @(posedge clk_sys) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    int done_cnt = 0;
    always @(negedge clk_sys) begin
        if (dl_done === 1'b1) done_cnt++;
    end

    typedef struct packed {
        logic [12:0] a;
        logic [7:0]  d;
    } ent_t;

    ent_t        q[$];
    logic [7:0]  mm [0:MSIZE-1];
    logic [15:0] exp_cnt  = '0;
    bit          exp_ovf  = 1'b0;
    bit          exp_rerr = 1'b0;
    bit          prev_act = 1'b0;
    bit          rd_pend  = 1'b0;
    logic [7:0]  rd_exp   = '0;
    int          checks   = 0;
    int          errors   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check last edge's results, drive, check the mux, advance the model
    task automatic step(input bit rd, input bit wr, input logic [15:0] ca, input logic [7:0] wd,
                        input bit act, input bit dwr, input logic [15:0] da, input logic [7:0] dd);
        bit   acc;
        bit   pp;
        ent_t h;
        @(negedge clk_sys);
        chk("dl_count", 32'(dl_count), 32'(exp_cnt));
        chk("dl_overflow", 32'(dl_overflow), 32'(exp_ovf));
        chk("dl_range_err", 32'(dl_range_err), 32'(exp_rerr));
        if (rd_pend) chk("cpu_rdata", 32'(cpu_rdata), 32'(rd_exp));
        rd_pend   = 1'b0;
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_addr  = ca;
        cpu_wdata = wd;
        dl_active = act;
        dl_wr     = dwr;
        dl_addr   = da;
        dl_data   = dd;
        #1;
        acc = (rd || wr) && (ca[15:13] == 3'b000);
        pp  = (q.size() > 0) && !acc;
        h   = '0;
        if (acc) begin
            chk("ram_we_cpu", 32'(ram_we), 32'(wr));
            chk("ram_addr_cpu", 32'(ram_addr), 32'(ca[12:0]));
            if (wr) chk("ram_din_cpu", 32'(ram_din), 32'(wd));
        end else if (pp) begin
            h = q[0];
            chk("ram_we_pop", 32'(ram_we), 32'd1);
            chk("ram_addr_pop", 32'(ram_addr), 32'(h.a));
            chk("ram_din_pop", 32'(ram_din), 32'(h.d));
        end else begin
            chk("ram_we_idle", 32'(ram_we), 32'd0);
        end
        if (acc && rd) begin
            rd_pend = 1'b1;
            rd_exp  = mm[ca[12:0]];
        end
        if (acc && wr) mm[ca[12:0]] = wd;
        if (pp) begin
            h = q.pop_front();
            mm[h.a] = h.d;
        end
        if (act && !prev_act) begin
            exp_cnt  = '0;
            exp_ovf  = 1'b0;
            exp_rerr = 1'b0;
        end
        prev_act = act;
        if (pp) exp_cnt = exp_cnt + 16'd1;
        if (dwr) begin
            if (da[15:13] != 3'b000) begin
                exp_rerr = 1'b1;
            end else if (q.size() < DEPTH) begin
                q.push_back({da[12:0], dd});
            end else begin
                exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    endtask

    task automatic mem_cmp(input string tag);
        int bad = 0;
        for (int i = 0; i < MSIZE; i++) begin
            if (ram[i] !== mm[i]) bad++;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    logic [7:0] bdata [0:15];
    int         dc0;
    bit         ract;
    bit         rrd;
    bit         rwr;
    logic [15:0] rca;
    logic [15:0] rda;

    initial begin
        for (int i = 0; i < MSIZE; i++) begin
            ram[i] = 8'h00;
            mm[i]  = 8'h00;
        end

        // Reset state
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("rst_dl_busy", 32'(dl_busy), 32'd0);
        chk("rst_dl_done", 32'(dl_done), 32'd0);
        chk("rst_dl_overflow", 32'(dl_overflow), 32'd0);
        chk("rst_dl_range_err", 32'(dl_range_err), 32'd0);
        chk("rst_dl_count", 32'(dl_count), 32'd0);
        reset = 1'b0;

        // CPU write then read with the downloader idle
        step(0, 1, 16'h0123, 8'h5A, 0, 0, 16'h0, 8'h0);
        chk("cpu_wr_we", 32'(ram_we), 32'd1);
        step(1, 0, 16'h0123, 8'h00, 0, 0, 16'h0, 8'h0);
        idle(1);
        chk("cpu_rd_data", 32'(cpu_rdata), 32'h5A);

        // Burst load with the CPU held
        dc0 = done_cnt;
        step(0, 0, 16'h0, 8'h0, 1, 0, 16'h0, 8'h0);
        step(0, 0, 16'h0, 8'h0, 1, 0, 16'h0, 8'h0);
        for (int i = 0; i < 16; i++) begin
            bdata[i] = 8'($urandom);
            step(0, 0, 16'h0, 8'h0, 1, 1, 16'h0280 + 16'(i), bdata[i]);
            chk("burst_cpu_hold", 32'(cpu_hold), 32'd1);
            chk("burst_dl_busy", 32'(dl_busy), 32'd1);
        end
        idle(6);
        chk("burst_done_pulses", 32'(done_cnt - dc0), 32'd1);
        chk("burst_count", 32'(dl_count), 32'd16);
        chk("burst_overflow", 32'(dl_overflow), 32'd0);
        chk("burst_hold_off", 32'(cpu_hold), 32'd0);
        chk("burst_busy_off", 32'(dl_busy), 32'd0);
        for (int i = 0; i < 16; i++) chk("burst_ram", 32'(ram[16'h0280 + i]), 32'(bdata[i]));

        // Contention: CPU busy while 3 bytes queue, one address collides
        step(0, 1, 16'h0400, 8'hC1, 0, 1, 16'h0300, 8'hA0);
        step(0, 1, 16'h0300, 8'hC2, 0, 1, 16'h0301, 8'hA1);
        step(1, 0, 16'h0400, 8'h00, 0, 1, 16'h0302, 8'hA2);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
            chk("cont_pop_we", 32'(ram_we), 32'd1);
            chk("cont_pop_addr", 32'(ram_addr), 32'h0300 + 32'(i));
        end
        step(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
        chk("cont_drained_we", 32'(ram_we), 32'd0);
        chk("cont_cpu_data", 32'(ram[16'h0400]), 32'hC1);
        chk("cont_fifo_wins", 32'(ram[16'h0300]), 32'hA0);

        // Overflow: 6 bytes into a 4-deep FIFO with the CPU busy
        step(0, 0, 16'h0, 8'h0, 1, 0, 16'h0, 8'h0);
        for (int i = 0; i < 6; i++)
            step(1, 0, 16'h0010, 8'h0, 1, 1, 16'h0500 + 16'(i), 8'h70 + 8'(i));
        idle(8);
        chk("ovf_flag", 32'(dl_overflow), 32'd1);
        chk("ovf_count", 32'(dl_count), 32'd4);
        chk("ovf_ram_kept", 32'(ram[16'h0503]), 32'h73);
        chk("ovf_ram_dropped", 32'(ram[16'h0504]), 32'h00);
        step(0, 0, 16'h0, 8'h0, 1, 0, 16'h0, 8'h0);
        step(0, 0, 16'h0, 8'h0, 1, 0, 16'h0, 8'h0);
        chk("ovf_cleared", 32'(dl_overflow), 32'd0);
        idle(6);

        // Range: only the in-range byte lands
        step(0, 0, 16'h0, 8'h0, 1, 0, 16'h0, 8'h0);
        step(0, 0, 16'h0, 8'h0, 1, 1, 16'hE000, 8'h11);
        step(0, 0, 16'h0, 8'h0, 1, 1, 16'h1FFF, 8'h22);
        idle(6);
        chk("range_err", 32'(dl_range_err), 32'd1);
        chk("range_count", 32'(dl_count), 32'd1);
        chk("range_ram_in", 32'(ram[16'h1FFF]), 32'h22);
        chk("range_ram_alias", 32'(ram[0]), 32'h00);
        mem_cmp("mem_directed");

        // Random traffic against the model
        ract = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(15) == 0) ract = ~ract;
            rrd = ($urandom_range(2) == 0);
            rwr = !rrd && ($urandom_range(2) == 0);
            rca = ($urandom_range(7) == 0) ? 16'($urandom) : {3'b000, 13'($urandom)};
            rda = ($urandom_range(7) == 0) ? 16'($urandom) : {3'b000, 13'($urandom)};
            step(rrd, rwr, rca, 8'($urandom), ract, bit'($urandom_range(1)), rda, 8'($urandom));
        end
        idle(10);
        mem_cmp("mem_random");

        // Reset with two bytes queued mid-load
        dc0 = done_cnt;
        step(1, 0, 16'h0020, 8'h0, 1, 0, 16'h0, 8'h0);
        step(1, 0, 16'h0020, 8'h0, 1, 1, 16'h0600, 8'h99);
        step(1, 0, 16'h0020, 8'h0, 1, 1, 16'h0601, 8'h98);
        chk("pre_rst_hold", 32'(cpu_hold), 32'd1);
        chk("pre_rst_busy", 32'(dl_busy), 32'd1);
        @(negedge clk_sys);
        reset = 1'b1;
        cpu_rd = 1'b0;
        dl_active = 1'b0;
        dl_wr = 1'b0;
        #1;
        chk("mid_rst_hold", 32'(cpu_hold), 32'd0);
        chk("mid_rst_busy", 32'(dl_busy), 32'd0);
        chk("mid_rst_we", 32'(ram_we), 32'd0);
        q.delete();
        exp_cnt  = '0;
        exp_ovf  = 1'b0;
        exp_rerr = 1'b0;
        prev_act = 1'b0;
        rd_pend  = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        idle(6);
        chk("mid_rst_no_done", 32'(done_cnt - dc0), 32'd0);
        chk("mid_rst_ram", 32'(ram[16'h0600]), 32'(mm[16'h0600]));
        mem_cmp("mem_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apple1_ram_arbiter.md
Name: apple1_ram_arbiter

Overview:
Shares the single-port 8 KB Apple-1 RAM between the CPU and the host file-download stream (user_io/data_io ioctl bytes), so binaries can be loaded into memory. The CPU always has priority. Download bytes go into a small FIFO and are written to RAM in cycles where the CPU makes no access. The block sits between apple1 and ram in apple1_mist and also produces the CPU hold and load-status signals.

Parameters:
RAM_AW, 13, RAM address width; RAM occupies 0 to 2^RAM_AW-1
FIFO_DEPTH, 4, download FIFO entries; must be a power of 2 and at least 2
HOLD_CPU, 1, 1 = assert cpu_hold for the whole load; 0 = CPU keeps running during the load

Ports:
clk_sys  in  1  system clock (clk14)
reset  in  1  asynchronous, active-high reset
cpu_addr  in  16  CPU address
cpu_wdata  in  8  CPU write data
cpu_rd  in  1  CPU read strobe, one clk_sys cycle per access
cpu_wr  in  1  CPU write strobe, one clk_sys cycle per access
cpu_rdata  out  8  read data to CPU; combinational copy of ram_dout
dl_active  in  1  download in progress (ioctl_download)
dl_wr  in  1  byte strobe, may be asserted every cycle
dl_addr  in  16  target address of the byte
dl_data  in  8  byte value
ram_addr  out  RAM_AW  RAM address
ram_din  out  8  RAM write data
ram_we  out  1  RAM write enable
ram_dout  in  8  RAM read data (synchronous RAM)
cpu_hold  out  1  hold CPU in reset; OR into the rst_n source
dl_busy  out  1  state is not IDLE
dl_done  out  1  one-cycle pulse when a load is complete
dl_overflow  out  1  sticky: at least one byte dropped because the FIFO was full
dl_range_err  out  1  sticky: at least one byte had dl_addr at or above 2^RAM_AW
dl_count  out  16  bytes written to RAM in the current or last load; wraps modulo 2^16

Behaviour:
- Reset values: state IDLE, FIFO empty, cpu_hold=0, dl_busy=0, dl_done=0, dl_overflow=0, dl_range_err=0, dl_count=0. ram_we is forced to 0 while reset is high.
- dl_active is sampled in a flop. Its rising edge (0 to 1 in the sample) clears dl_overflow, dl_range_err and dl_count.
- State machine:
  - IDLE: goes to LOAD on dl_active=1.
  - LOAD: goes to DRAIN when dl_active=0.
  - DRAIN: goes to DONE when the FIFO is empty and no pop happens this cycle; goes back to LOAD if dl_active rises again.
  - DONE: lasts one cycle, dl_done=1, then IDLE.
- cpu_hold = HOLD_CPU and (state is LOAD or DRAIN). It is a registered output and rises the cycle after LOAD is entered.
- Push: dl_wr=1 with dl_addr below 2^RAM_AW. The entry stores {dl_addr[RAM_AW-1:0], dl_data}. dl_wr with an out-of-range address sets dl_range_err and is not pushed. dl_wr is accepted in any state, including IDLE.
- CPU access:
  - cpu_acc = (cpu_rd or cpu_wr) and cpu_addr[15:RAM_AW]==0.
  - CPU accesses outside that range leave the RAM untouched, with ram_we=0.
- Pop condition (evaluated every cycle): FIFO not empty and cpu_acc=0. Valid in any state.
- RAM port mux (combinational):
  - cpu_acc=1: ram_addr=cpu_addr[RAM_AW-1:0], ram_din=cpu_wdata, ram_we=cpu_wr.
  - Pop: ram_addr and ram_din come from the FIFO head, ram_we=1.
  - Otherwise: ram_addr=cpu_addr[RAM_AW-1:0], ram_we=0.
- Latency:
  - A byte pushed in cycle N is at the head in N+1, so it is written no earlier than N+1.
  - CPU reads keep the existing one-cycle synchronous RAM latency; cpu_rdata is valid the cycle after cpu_rd.
- Full FIFO:
  - Push and pop in the same cycle are both accepted, and the count is unchanged.
  - Push with no pop: the byte is dropped and dl_overflow is set.
- Empty FIFO: no pop; the RAM stays with the CPU.
- dl_count increments on every pop. FIFO pointers wrap modulo FIFO_DEPTH.
- Byte ordering: RAM writes happen in push order. If the same address is pushed twice, the later byte is the final value.
- A CPU write and a pending FIFO entry for the same address: the CPU write lands first, the FIFO write lands later and wins.
- Reset during LOAD or DRAIN: the FIFO is discarded, state returns to IDLE, cpu_hold drops asynchronously, and no dl_done is produced.

Test Plan:
- Idle CPU: cpu_wr addr 0x0123 data 0x5A, then cpu_rd 0x0123 -> ram_we=1 in the write cycle, cpu_rdata=0x5A one cycle after cpu_rd.
- Burst load, HOLD_CPU=1: dl_active, 16 back-to-back dl_wr to 0x0280..0x028F, then dl_active=0 -> cpu_hold=1 throughout, dl_count=16, one dl_done pulse, RAM matches the bytes, dl_overflow=0.
- Contention, HOLD_CPU=0: CPU accesses every cycle while 3 bytes are pushed -> no RAM write from the FIFO; when the CPU idles, 3 consecutive ram_we pops, CPU data intact.
- Overflow: CPU busy continuously, 6 dl_wr with FIFO_DEPTH=4 -> first 4 written after the CPU idles, dl_overflow=1, dl_count=4; the next dl_active rising edge clears dl_overflow.
- Range: dl_wr to 0xE000 and 0x1FFF -> only 0x1FFF written, dl_range_err=1, dl_count=1.
- Reset mid-load: assert reset with 2 entries queued -> FIFO empty, cpu_hold=0 immediately, no dl_done pulse, no further ram_we.
